// File: rtl/ps2_mouse_tracker_pkg.sv
// Shared PS/2 command bytes, control-FSM encoding and screen bounds
// used by the mouse tracker and the VGA/object machines.
package ps2_mouse_tracker_pkg;

  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_ACK        = 8'hFA;

  localparam int SCREEN_W_PX = 640;
  localparam int SCREEN_H_PX = 480;

  typedef enum logic [2:0] {
    ST_INHIBIT,
    ST_TX_BITS,
    ST_TX_ACK,
    ST_WAIT_FA,
    ST_RUN
  } ctrl_state_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 pad synchroniser, falling-edge detector and 11-bit receive framer
// with odd-parity check and idle timeout.
module ps2_rx_byte
  import ps2_mouse_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       en,
  input  logic       pkt_pending,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       err,
  output logic       timeout,
  output logic       fall_edge,
  output logic       data_sync
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_prev;
  logic [3:0]    bit_idx;
  logic [7:0]    sr;
  logic          par;
  logic [IW-1:0] idle;
  logic          at_stop;
  logic          frame_ok;
  logic          bad_start;

  assign fall_edge  = clk_prev & ~clk_sync[1];
  assign data_sync  = dat_sync[1];
  assign data_byte  = sr;
  assign at_stop    = en & fall_edge & (bit_idx == 4'd10);
  assign frame_ok   = data_sync & (par == odd_parity(sr));
  assign bad_start  = en & fall_edge & (bit_idx == 4'd0) & data_sync;
  // Idle timeout only matters while a frame or a packet is half-received.
  assign timeout    = en & ~fall_edge & (idle == '0) & ((bit_idx != 4'd0) | pkt_pending);
  assign byte_valid = at_stop & frame_ok;
  assign err        = bad_start | (at_stop & ~frame_ok) | timeout;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync <= '0;
      dat_sync <= '0;
      clk_prev <= 1'b0;
      bit_idx  <= '0;
      sr       <= '0;
      par      <= 1'b0;
      idle     <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_i};
      dat_sync <= {dat_sync[0], ps2_data_i};
      clk_prev <= clk_sync[1];

      if (fall_edge || timeout) idle <= IW'(TIMEOUT_CYCLES - 1);
      else if (idle != '0)      idle <= idle - IW'(1);

      if (!en || timeout) begin
        bit_idx <= '0;
      end else if (fall_edge) begin
        if (bit_idx == 4'd0) begin
          if (!data_sync) bit_idx <= 4'd1;
        end else if (bit_idx <= 4'd8) begin
          sr      <= {data_sync, sr[7:1]};
          bit_idx <= bit_idx + 4'd1;
        end else if (bit_idx == 4'd9) begin
          par     <= data_sync;
          bit_idx <= bit_idx + 4'd1;
        end else begin
          bit_idx <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse front end: enables streaming, then turns 3-byte packets into a
// screen-clamped cursor position and button state.
//
// state      | meaning
// INHIBIT    | hold PS/2 clock low before a host transmit
// TX_BITS    | shift 0xF4 + parity + stop out on device clock falls
// TX_ACK     | wait for the device line-ack (data low on a clock fall)
// WAIT_FA    | wait for the 0xFA acknowledge byte
// RUN        | assemble movement packets and update the cursor
module ps2_mouse_tracker
  import ps2_mouse_tracker_pkg::*;
#(
  parameter int SCREEN_W       = SCREEN_W_PX,
  parameter int SCREEN_H       = SCREEN_H_PX,
  parameter int INIT_X         = 320,
  parameter int INIT_Y         = 240,
  parameter int INHIBIT_CYCLES = 15000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [9:0] mousex,
  output logic [9:0] mousey,
  output logic       mousepush,
  output logic       mouseright,
  output logic       packet_valid,
  output logic       init_done,
  output logic       frame_err
);

  localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [9:0] TX_FRAME = {1'b1, odd_parity(PS2_CMD_ENABLE), PS2_CMD_ENABLE};
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - 1);

  ctrl_state_t  state;
  logic [TW-1:0] tmr;
  logic [3:0]   tx_idx;
  logic [1:0]   byte_idx;
  logic [5:0]   hdr;      // {y_ovf, x_ovf, y_sign, x_sign, right, left}
  logic [7:0]   dx_lo;

  logic [7:0]   rx_byte;
  logic         rx_valid, rx_err, rx_timeout, fall_edge, data_sync, rx_en;
  logic signed [11:0] dx, dy, nx, ny;
  logic [9:0]   nx_c, ny_c;

  assign rx_en = (state == ST_WAIT_FA) || (state == ST_RUN);

  ps2_rx_byte #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .en         (rx_en),
    .pkt_pending(byte_idx != 2'd0),
    .data_byte  (rx_byte),
    .byte_valid (rx_valid),
    .err        (rx_err),
    .timeout    (rx_timeout),
    .fall_edge  (fall_edge),
    .data_sync  (data_sync)
  );

  // PS/2 y grows upward, screen y grows downward.
  always_comb begin
    dx = hdr[4] ? 12'sd0 : {{4{hdr[2]}}, dx_lo};
    dy = hdr[5] ? 12'sd0 : {{4{hdr[3]}}, rx_byte};
    nx = $signed({2'b00, mousex}) + dx;
    ny = $signed({2'b00, mousey}) - dy;
    if (nx[11])          nx_c = '0;
    else if (nx > X_MAX) nx_c = X_MAX[9:0];
    else                 nx_c = nx[9:0];
    if (ny[11])          ny_c = '0;
    else if (ny > Y_MAX) ny_c = Y_MAX[9:0];
    else                 ny_c = ny[9:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_INHIBIT;
      tmr          <= TW'(INHIBIT_CYCLES);
      tx_idx       <= '0;
      byte_idx     <= '0;
      hdr          <= '0;
      dx_lo        <= '0;
      ps2_clk_oe   <= 1'b0;
      ps2_data_oe  <= 1'b0;
      mousex       <= 10'(INIT_X);
      mousey       <= 10'(INIT_Y);
      mousepush    <= 1'b0;
      mouseright   <= 1'b0;
      packet_valid <= 1'b0;
      init_done    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      frame_err    <= rx_err;
      case (state)
        ST_INHIBIT: begin
          if (tmr == '0) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            tx_idx      <= '0;
            state       <= ST_TX_BITS;
          end else begin
            ps2_clk_oe <= 1'b1;
            tmr        <= tmr - TW'(1);
          end
        end
        ST_TX_BITS: begin
          if (fall_edge) begin
            ps2_data_oe <= ~TX_FRAME[tx_idx];
            if (tx_idx == 4'd9) begin
              tmr   <= TW'(TIMEOUT_CYCLES - 1);
              state <= ST_TX_ACK;
            end else begin
              tx_idx <= tx_idx + 4'd1;
            end
          end
        end
        ST_TX_ACK: begin
          if (fall_edge && !data_sync) begin
            tmr   <= TW'(TIMEOUT_CYCLES - 1);
            state <= ST_WAIT_FA;
          end else if (tmr == '0) begin
            frame_err   <= 1'b1;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            tmr         <= TW'(INHIBIT_CYCLES - 1);
            state       <= ST_INHIBIT;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        ST_WAIT_FA: begin
          if (rx_valid && rx_byte == PS2_ACK) begin
            init_done <= 1'b1;
            byte_idx  <= '0;
            state     <= ST_RUN;
          end else if (rx_timeout || (tmr == '0 && !fall_edge)) begin
            frame_err  <= 1'b1;
            ps2_clk_oe <= 1'b1;
            tmr        <= TW'(INHIBIT_CYCLES - 1);
            state      <= ST_INHIBIT;
          end else if (fall_edge) begin
            tmr <= TW'(TIMEOUT_CYCLES - 1);
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        ST_RUN: begin
          if (rx_timeout) begin
            byte_idx <= '0;
          end else if (rx_valid) begin
            case (byte_idx)
              2'd0: begin
                // Header bit 3 is always set; anything else is a misaligned byte.
                if (rx_byte[3]) begin
                  hdr      <= {rx_byte[7:4], rx_byte[1:0]};
                  byte_idx <= 2'd1;
                end
              end
              2'd1: begin
                dx_lo    <= rx_byte;
                byte_idx <= 2'd2;
              end
              default: begin
                mousex       <= nx_c;
                mousey       <= ny_c;
                mousepush    <= hdr[0];
                mouseright   <= hdr[1];
                packet_valid <= 1'b1;
                byte_idx     <= 2'd0;
              end
            endcase
          end
        end
        default: state <= ST_INHIBIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: PS/2 device model on the open-drain bus and a
// packet-level cursor model.
module tb_ps2_mouse_tracker;

  localparam int H   = 10;     // device clock half-period in clk cycles
  localparam int INH = 15000;
  localparam int TMO = 3000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic [9:0] mousex, mousey;
  logic mousepush, mouseright, packet_valid, init_done, frame_err;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_mouse_tracker #(
    .SCREEN_W(640), .SCREEN_H(480), .INIT_X(320), .INIT_Y(240),
    .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .mousex(mousex), .mousey(mousey), .mousepush(mousepush), .mouseright(mouseright),
    .packet_valid(packet_valid), .init_done(init_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int pv_cnt = 0, fe_cnt = 0, lat = -1;
  int mx = 320, my = 240, mpush = 0, mright = 0, exp_pv = 0, exp_fe = 0, midx = 0;
  logic [7:0] mb0, mb1;

  always @(negedge clk) begin
    if (packet_valid) pv_cnt++;
    if (frame_err) fe_cnt++;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: bench exceeded cycle budget");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int dx, dy;
    if (midx == 0) begin
      if (b[3]) begin mb0 = b; midx = 1; end
    end else if (midx == 1) begin
      mb1 = b; midx = 2;
    end else begin
      dx = mb0[6] ? 0 : (mb0[4] ? int'(mb1) - 256 : int'(mb1));
      dy = mb0[7] ? 0 : (mb0[5] ? int'(b) - 256 : int'(b));
      mx = clampi(mx + dx, 639);
      my = clampi(my - dy, 479);
      mpush = int'(mb0[0]);
      mright = int'(mb0[1]);
      exp_pv++;
      midx = 0;
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, ~(^b) ^ bad_par, b, 1'b0};
  endfunction

  // Device-to-host: data changes while clock high, host samples on the fall.
  task automatic tx_raw(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = frame(b, bad_par);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      dev_data_low = ~fr[i];
      repeat (H / 2) @(negedge clk);
      lat = -1;
      dev_clk_low = 1'b1;
      for (int j = 1; j <= H; j++) begin
        @(negedge clk);
        if (packet_valid && lat < 0) lat = j;
      end
      dev_clk_low = 1'b0;
      repeat (H / 2) @(negedge clk);
    end
    dev_data_low = 1'b0;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    tx_raw(b, 1'b0, 11);
    model_byte(b);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_x"}, int'(mousex), mx);
    chk({tag, "_y"}, int'(mousey), my);
    chk({tag, "_push"}, int'(mousepush), mpush);
    chk({tag, "_right"}, int'(mouseright), mright);
    chk({tag, "_pv_cnt"}, pv_cnt, exp_pv);
    chk({tag, "_fe_cnt"}, fe_cnt, exp_fe);
  endtask

  task automatic send_pkt(input string tag, input logic [7:0] b0, b1, b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    check_state(tag);
  endtask

  task automatic send_move(input string tag, input logic [1:0] btn, input int dx, input int dy);
    logic [8:0] dx9, dy9;
    dx9 = dx[8:0];
    dy9 = dy[8:0];
    send_pkt(tag, {2'b00, dy9[8], dx9[8], 2'b10, btn}, dx9[7:0], dy9[7:0]);
  endtask

  initial begin
    logic [9:0] got;
    int n;
    logic [7:0] r0, r1, r2;

    repeat (4) @(negedge clk);
    chk("rst_x", int'(mousex), 320);
    chk("rst_y", int'(mousey), 240);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("rst_data_oe", int'(ps2_data_oe), 0);
    chk("rst_pv", int'(packet_valid), 0);
    rstn = 1'b1;

    n = 0;
    while (!ps2_clk_oe && n < 10) begin @(negedge clk); n++; end
    chk("inhibit_start", int'(ps2_clk_oe), 1);
    n = 0;
    while (ps2_clk_oe && n < INH + 100) begin @(negedge clk); n++; end
    chk("inhibit_len", n, INH);
    chk("tx_start_bit", int'(ps2_data_oe), 1);

    repeat (5) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      got[i] = ps2_data_i;
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clk);
    end
    chk("tx_byte", int'(got[7:0]), 'hF4);
    chk("tx_parity", int'(got[8]), 0);
    chk("tx_stop", int'(got[9]), 1);
    dev_data_low = 1'b1;
    repeat (H / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (H) @(negedge clk);
    dev_data_low = 1'b0;
    repeat (H) @(negedge clk);
    chk("pre_fa_init_done", int'(init_done), 0);

    tx_raw(8'hFA, 1'b0, 11);
    chk("init_done", int'(init_done), 1);
    check_state("after_fa");

    send_pkt("pkt_09", 8'h09, 8'h05, 8'h03);
    chk("pkt_09_latency", lat, 3);
    chk("pkt_09_x_const", int'(mousex), 325);
    chk("pkt_09_y_const", int'(mousey), 237);
    chk("pkt_09_push_const", int'(mousepush), 1);

    send_move("move_a", 2'b00, -255, -241);
    send_move("move_b", 2'b00, -68, 0);
    chk("at_2_478_x", int'(mousex), 2);
    chk("at_2_478_y", int'(mousey), 478);
    send_pkt("clamp_left", 8'h18, 8'hF0, 8'h00);
    chk("clamp_left_const", int'(mousex), 0);
    send_pkt("clamp_bottom", 8'h28, 8'h00, 8'hF0);
    chk("clamp_bottom_const", int'(mousey), 479);

    send_pkt("x_ovf", 8'h48, 8'h7F, 8'h02);
    chk("x_ovf_x_const", int'(mousex), 0);
    chk("x_ovf_y_const", int'(mousey), 477);

    send_byte(8'h01);
    chk("stray_no_pv", pv_cnt, exp_pv);
    send_pkt("after_stray", 8'h0A, 8'h10, 8'h08);

    tx_raw(8'h08, 1'b1, 11);
    exp_fe++;
    check_state("bad_parity");
    send_pkt("after_parity", 8'h08, 8'h03, 8'h01);

    tx_raw(8'h08, 1'b0, 6);
    repeat (TMO + 200) @(negedge clk);
    exp_fe++;
    check_state("bit_timeout");
    send_pkt("after_bit_timeout", 8'h09, 8'h20, 8'hE0);

    send_byte(8'h08);
    repeat (TMO + 200) @(negedge clk);
    exp_fe++;
    midx = 0;
    check_state("pkt_timeout");
    send_pkt("after_pkt_timeout", 8'h0B, 8'h40, 8'h00);

    for (int k = 0; k < 20; k++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      r0[3] = 1'b1;
      if ($urandom_range(0, 3) != 0) r0[7:6] = 2'b00;
      send_pkt("random", r0, r1, r2);
    end

    tx_raw(8'h09, 1'b0, 5);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_x", int'(mousex), 320);
    chk("midrst_y", int'(mousey), 240);
    chk("midrst_push", int'(mousepush), 0);
    chk("midrst_init_done", int'(init_done), 0);
    chk("midrst_clk_oe", int'(ps2_clk_oe), 0);
    chk("midrst_data_oe", int'(ps2_data_oe), 0);
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    n = 0;
    while (!ps2_clk_oe && n < 10) begin @(negedge clk); n++; end
    chk("reinit_inhibit", int'(ps2_clk_oe), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_tracker.md
Name: ps2_mouse_tracker

Overview:
- Produces the cursor inputs `mousex`, `mousey` and `mousepush` that the object/score machine consumes for slice detection.
- After reset it sends the PS/2 "enable data reporting" command (0xF4) and waits for the 0xFA acknowledge.
- It then receives 3-byte streaming packets and accumulates the signed deltas into a screen-clamped cursor position.
- Sits between the top-level open-drain PS/2 pads and the game logic, in the same `clk` domain as the VGA and object machines.

Parameters:
- SCREEN_W, 640, horizontal clamp bound (x in 0..SCREEN_W-1)
- SCREEN_H, 480, vertical clamp bound (y in 0..SCREEN_H-1)
- INIT_X, 320, cursor x after reset
- INIT_Y, 240, cursor y after reset
- INHIBIT_CYCLES, 15000, `clk` cycles the PS/2 clock is held low before transmit (150 us at 100 MHz)
- TIMEOUT_CYCLES, 200000, idle `clk` cycles mid-frame or mid-packet before the framer resynchronises

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous assert, active-low
- ps2_clk_i  in  1  raw PS/2 clock pad input
- ps2_data_i  in  1  raw PS/2 data pad input
- ps2_clk_oe  out  1  1 = drive PS/2 clock low (open drain)
- ps2_data_oe  out  1  1 = drive PS/2 data low (open drain)
- mousex  out  10  cursor x, unsigned pixel
- mousey  out  10  cursor y, unsigned pixel, 0 = top
- mousepush  out  1  left button held
- mouseright  out  1  right button held
- packet_valid  out  1  one-cycle pulse when outputs update
- init_done  out  1  high once 0xFA is received; stays high until reset
- frame_err  out  1  one-cycle pulse on a parity, start or stop error, or a timeout

Behaviour:
- Reset values:
  - mousex = INIT_X, mousey = INIT_Y.
  - mousepush, mouseright, packet_valid, init_done, frame_err = 0.
  - ps2_clk_oe = ps2_data_oe = 0.
  - All counters and FSM registers cleared; the FSM enters INHIBIT.
- Input conditioning:
  - ps2_clk_i and ps2_data_i each pass through a 2-FF synchroniser.
  - A falling edge = synchronised clock was 1 last cycle and is 0 now.
  - Data is sampled on the falling-edge cycle.
- Receive framer (11 bits):
  - Frame order: start(0), d0..d7 LSB first, odd parity, stop(1).
  - A bad start, bad stop or bad parity discards the byte and pulses frame_err.
  - An idle counter resets on every falling edge.
  - If it reaches TIMEOUT_CYCLES with a partial frame or partial packet pending, the bit and byte indices clear and frame_err pulses.
  - The framer is active only in WAIT_FA and RUN; it ignores edges during transmit.
- Control FSM:
  - INHIBIT: ps2_clk_oe = 1 for INHIBIT_CYCLES, then ps2_data_oe = 1 and ps2_clk_oe = 0 -> TX_BITS.
  - TX_BITS: on each device falling edge, present the next bit (0xF4 LSB first, then odd parity = 0, then stop).
    - ps2_data_oe = ~bit.
    - The stop bit releases data.
    - Move to TX_ACK after the stop edge.
  - TX_ACK: wait for the falling edge with data = 0 -> WAIT_FA.
    - No ack within TIMEOUT_CYCLES -> pulse frame_err, go to INHIBIT (retry).
  - WAIT_FA: a received byte 0xFA -> set init_done, go to RUN.
    - Any other byte is discarded.
    - A timeout -> INHIBIT.
  - RUN: packet assembly, permanently until reset.
- Packet assembly (RUN):
  - Byte index 0..2.
  - Byte 0 is accepted only if bit3 = 1; otherwise it is dropped and the index stays 0 (alignment recovery).
  - Fields:
    - b0[0] = left button, b0[1] = right button.
    - dx = signed 9-bit {b0[4], b1}; dy = signed 9-bit {b0[5], b2}.
    - b0[6] = X overflow: forces dx = 0. b0[7] = Y overflow: forces dy = 0.
- Cursor update:
  - Triggered on the cycle after byte 2's stop bit is sampled.
  - Computed in 12-bit signed: nx = mousex + dx, ny = mousey - dy (PS/2 y is positive up).
  - Clamp: <0 -> 0; >SCREEN_W-1 -> SCREEN_W-1; >SCREEN_H-1 -> SCREEN_H-1.
  - mousex, mousey, mousepush and mouseright all register in that cycle, and packet_valid pulses in that cycle.
  - Latency: 1 `clk` after the last stop-bit sample.
- Outputs are held between packets. Buttons are never auto-released; they change only on a valid packet.
- Reset mid-frame or mid-transmit: the open-drain enables release immediately (asynchronous), and the full init sequence repeats.

Decomposition:
- Shared package:
  - PS2_CMD_ENABLE = 8'hF4 and PS2_ACK = 8'hFA.
  - Control FSM state encoding (INHIBIT, TX_BITS, TX_ACK, WAIT_FA, RUN).
  - Screen size constants, shared with the VGA and object machines.
- One sub-module, ps2_rx_byte:
  - Contains the synchroniser, edge detector, 11-bit framer, parity check and timeout.
  - Outputs byte[7:0], a byte_valid pulse, an err pulse and fall_edge (reused by the TX path).

Test Plan:
- Reset, then the bench device model clocks in the command and acks, then sends 0xFA:
  - ps2_clk_oe is high for exactly 15000 cycles.
  - The captured host byte is 0xF4 with parity 0.
  - init_done rises; mousex = 320, mousey = 240.
- Packet 0x09, 0x05, 0x03:
  - mousex = 325, mousey = 237, mousepush = 1.
  - packet_valid pulses once, 1 cycle after the final stop sample.
- Cursor at (2, 478), packet 0x18, 0xF0, 0x00 (dx = -16, dy = 0):
  - mousex = 0 (clamped). Then packet 0x28, 0x00, 0xF0 (dy = -16) -> mousey = 479.
- Packet 0x48, 0x7F, 0x02 (X overflow set):
  - mousex unchanged, mousey decreases by 2, mousepush = 0.
- Stray byte 0x01, then a valid packet:
  - 0x01 is dropped (bit3 = 0).
  - The following 3 bytes form one packet and packet_valid pulses once.
- Error cases:
  - Byte with a wrong parity bit -> frame_err pulses; no update.
  - 6 bits sent, then idle for 200000 cycles -> frame_err pulses; a following clean packet updates normally.
  - rstn asserted mid-packet -> outputs return to reset values immediately.
